// File: rtl/tuple_range_pkg.sv
// ============================================================================
// Module : tuple_range_pkg
// Brief  : Shared state encoding and sizing constants for tuple_range_flatten.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tuple_range_pkg;

    localparam int MAX_ARITY = 8;
    localparam int IDX_W     = $clog2(MAX_ARITY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hrange_tuple.sv
// ============================================================================
// Module : hrange_tuple
// Brief  : Signed range generator yielding (i, i+1, .., i+ARITY-1) per step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hrange_tuple #(
    parameter int WIDTH = 32,
    parameter int ARITY = 2
) (
    input  logic                     _clock,
    input  logic                     _reset_n,
    input  logic                     _start,
    input  logic [WIDTH-1:0]         base,
    input  logic [WIDTH-1:0]         limit,
    input  logic [WIDTH-1:0]         step,
    input  logic                     _ready,
    output logic                     _valid,
    output logic                     _done,
    output logic [ARITY*WIDTH-1:0]   tuple
);

    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   sum;
    logic             ovf;

    assign _valid = run_q && ($signed(i_q) < $signed(limit_q))
                    && !step_q[WIDTH-1] && (step_q != '0);
    assign _done  = !_valid;

    // One guard bit catches signed overflow of i+step, which ends the sequence.
    assign sum = {i_q[WIDTH-1], i_q} + {step_q[WIDTH-1], step_q};
    assign ovf = sum[WIDTH] ^ sum[WIDTH-1];

    for (genvar k = 0; k < ARITY; k++) begin : g_elem
        assign tuple[k*WIDTH +: WIDTH] = i_q + WIDTH'(k);
    end

    always_comb begin
        i_d     = i_q;
        limit_d = limit_q;
        step_d  = step_q;
        run_d   = run_q;
        if (_valid && _ready) begin
            if (ovf) begin
                run_d = 1'b0;
            end else begin
                i_d = sum[WIDTH-1:0];
            end
        end
        if (_start) begin
            i_d     = base;
            limit_d = limit;
            step_d  = step;
            run_d   = 1'b1;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            i_q     <= '0;
            limit_q <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            i_q     <= i_d;
            limit_q <= limit_d;
            step_q  <= step_d;
            run_q   <= run_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tuple_range_flatten.sv
// ============================================================================
// Module : tuple_range_flatten
// Brief  : Flattens hrange_tuple tuples into a scalar ready/valid stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tuple_range_flatten
    import tuple_range_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ARITY = 2
) (
    input  logic             _clock,
    input  logic             _reset_n,
    input  logic             _start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             _ready,
    output logic             _valid,
    output logic [WIDTH-1:0] _0,
    output logic [2:0]       _index,
    output logic             _done
);

    localparam int               TW       = ARITY * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARITY - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    emit_q, emit_d;
    logic [TW-1:0]    pf_q, pf_d;
    logic             pf_full_q, pf_full_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic             child_valid, child_done, child_ready, child_acc;
    logic [TW-1:0]    child_tuple;
    logic             xfer, xfer_last, pf_drain;

    hrange_tuple #(
        .WIDTH (WIDTH),
        .ARITY (ARITY)
    ) u_child (
        ._clock   (_clock),
        ._reset_n (_reset_n),
        ._start   (_start),
        .base     (base),
        .limit    (limit),
        .step     (step),
        ._ready   (child_ready),
        ._valid   (child_valid),
        ._done    (child_done),
        .tuple    (child_tuple)
    );

    assign xfer      = valid_q && _ready;
    assign xfer_last = xfer && (idx_q == LAST_IDX);
    // The slot counts as free when it is being moved into the emit register this cycle.
    assign pf_drain    = pf_full_q && ((state_q == ST_FETCH) ||
                                       ((state_q == ST_EMIT) && xfer_last));
    assign child_ready = (state_q != ST_IDLE) && (!pf_full_q || pf_drain);
    assign child_acc   = child_valid && child_ready;

    always_comb begin
        state_d   = state_q;
        emit_d    = emit_q;
        pf_d      = pf_q;
        pf_full_d = pf_full_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        done_d    = done_q;
        if (child_acc) begin
            pf_d      = child_tuple;
            pf_full_d = 1'b1;
        end else if (pf_drain) begin
            pf_full_d = 1'b0;
        end
        case (state_q)
            ST_FETCH: begin
                if (pf_full_q) begin
                    emit_d  = pf_q;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end else if (child_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (xfer_last) begin
                    if (pf_full_q) begin
                        emit_d = pf_q;
                        idx_d  = '0;
                    end else if (child_acc) begin
                        // Empty slot: take the arriving tuple straight to the output.
                        emit_d    = child_tuple;
                        idx_d     = '0;
                        pf_full_d = 1'b0;
                    end else if (child_done) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        valid_d = 1'b0;
                    end
                end else if (xfer) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        if (_start) begin
            state_d   = ST_FETCH;
            pf_full_d = 1'b0;
            idx_d     = '0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q   <= ST_IDLE;
            emit_q    <= '0;
            pf_q      <= '0;
            pf_full_q <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            emit_q    <= emit_d;
            pf_q      <= pf_d;
            pf_full_q <= pf_full_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _index = idx_q;
    assign _0     = emit_q[int'(idx_q)*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_tuple_range_flatten.sv
// ============================================================================
// Module : tb_tuple_range_flatten
// Brief  : Scoreboard bench driving three arity variants with shared stimulus.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tuple_range_flatten;

    localparam int NI = 3;
    localparam int AR [NI] = '{2, 3, 1};

    typedef struct packed {
        logic [31:0] val;
        logic [2:0]  idx;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] base  = '0;
    logic [31:0] limit = '0;
    logic [31:0] step  = '0;

    logic        dv [NI];
    logic [31:0] d0 [NI];
    logic [2:0]  di [NI];
    logic        dd [NI];

    exp_t sbq [NI][$];
    bit   stalled  [NI];
    exp_t held     [NI];
    bit   exp_done [NI];
    int   nelem    [NI];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        tuple_range_flatten #(
            .WIDTH (32),
            .ARITY (AR[g])
        ) u_dut (
            ._clock   (clk),
            ._reset_n (rst_n),
            ._start   (start),
            .base     (base),
            .limit    (limit),
            .step     (step),
            ._ready   (ready),
            ._valid   (dv[g]),
            ._0       (d0[g]),
            ._index   (di[g]),
            ._done    (dd[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    if (exp_done[i]) begin
                        check($sformatf("done_after_last[%0d]", i), {dd[i], dv[i]}, 2'b10);
                        exp_done[i] = 1'b0;
                    end
                    if (stalled[i] && dv[i])
                        check($sformatf("stall_hold[%0d]", i), {d0[i], di[i]}, held[i]);
                    stalled[i] = 1'b0;
                    if (dv[i] && ready) begin
                        if (sbq[i].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_elem[%0d]: got 0x%0h required none", i, d0[i]);
                        end else begin
                            check($sformatf("elem[%0d]", i), {d0[i], di[i]}, sbq[i].pop_front());
                            if (sbq[i].size() == 0 && !start) exp_done[i] = 1'b1;
                        end
                    end else if (dv[i]) begin
                        stalled[i] = 1'b1;
                        held[i]    = '{val: d0[i], idx: di[i]};
                    end
                end
            end
        end
    endtask

    // Reference: walk the range with wide arithmetic, stop on i>=limit or 32-bit overflow.
    task automatic start_seq(input int b, input int l, input int s);
        base  = b;
        limit = l;
        step  = s;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            longint v;
            sbq[i].delete();
            stalled[i]  = 1'b0;
            exp_done[i] = 1'b0;
            v = b;
            if (s > 0) begin
                while (v < l) begin
                    for (int k = 0; k < AR[i]; k++)
                        sbq[i].push_back('{val: 32'(v + k), idx: 3'(k)});
                    v += s;
                    if (v > 64'sd2147483647) break;
                end
            end
            nelem[i] = sbq[i].size();
        end
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int mode);
        int nv [NI];
        bit fin;
        bit all_empty;
        fin = 1'b0;
        all_empty = 1'b1;
        for (int i = 0; i < NI; i++) begin
            nv[i] = 0;
            if (nelem[i] != 0) all_empty = 1'b0;
        end
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk);
            #1;
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++) begin
                if (c == 1) check($sformatf("latency_edge1[%0d]", i), dv[i], 1'b0);
                if (c == 2) check($sformatf("latency_edge2[%0d]", i), dv[i], nelem[i] != 0);
                if (dv[i]) nv[i]++;
            end
            fin = 1'b1;
            for (int i = 0; i < NI; i++)
                if (!dd[i] || dv[i] || sbq[i].size() != 0) fin = 1'b0;
            if (fin) begin
                if (all_empty) check("empty_done_within3", c <= 3, 1'b1);
                break;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got busy required idle within 600 cycles");
        end
        if (mode == 0 && fin)
            for (int i = 0; i < NI; i++)
                check($sformatf("no_bubble[%0d]", i), nv[i], nelem[i]);
    endtask

    task automatic run(input int b, input int l, input int s, input int mode);
        start_seq(b, l, s);
        wait_idle(mode);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_valid[%0d]", i), dv[i], 1'b0);
            check($sformatf("reset_done[%0d]", i), dd[i], 1'b1);
            check($sformatf("reset_out[%0d]", i), {d0[i], di[i]}, '0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(0, 10, 2, 0);
        run(0, 10, 2, 1);
        run(5, 5, 1, 0);
        run(0, 10, 0, 0);
        run(-4, 4, 3, 0);

        // Restart while the fourth element is on the output.
        ready = 1'b1;
        start_seq(0, 10, 2);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        run(100, 102, 1, 0);

        // Asynchronous abort mid-sequence, then a fresh run.
        start_seq(0, 10, 2);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abort_valid[%0d]", i), dv[i], 1'b0);
            check($sformatf("abort_done[%0d]", i), dd[i], 1'b1);
            sbq[i].delete();
            stalled[i]  = 1'b0;
            exp_done[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(3, 9, 2, 0);

        run(32'h7FFF_FFFD, 32'h7FFF_FFFF, 2, 0);
        run(32'h7FFF_FFFD, 32'h7FFF_FFFF, 5, 0);
        run(32'h7FFF_FFF0, 32'h7FFF_FFFF, 4, 2);

        for (int r = 0; r < 25; r++) begin
            int b;
            int l;
            int s;
            b = int'($urandom_range(0, 60)) - 30;
            l = b + int'($urandom_range(0, 24)) - 4;
            s = int'($urandom_range(0, 5)) - 1;
            run(b, l, s, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
